// File: rtl/uart_pwm_led_pkg.sv
// rtl/uart_pwm_led_pkg.sv - shared constants and types for the UART LED controller
package uart_pwm_led_pkg;

    localparam logic [7:0] RESP_ACK      = 8'h06;
    localparam logic [7:0] RESP_NAK      = 8'h15;
    localparam int         CMD_WRITE_BIT = 7;
    localparam int         CMD_INDEX_MSB = 6;
    localparam int         CMD_INDEX_W   = CMD_INDEX_MSB + 1;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DATA = 1'b1
    } state_t;

endpackage

// File: rtl/uart_pwm_led_pwm.sv
// rtl/uart_pwm_led_pwm.sv - prescaled PWM counter with period-aligned duty transfer
module uart_pwm_led_pwm #(
    parameter int NumLeds     = 8,
    parameter int PwmBits     = 8,
    parameter int PrescaleDiv = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NumLeds-1:0][PwmBits-1:0]  shadow,
    output logic [NumLeds-1:0]               led
);

    localparam int PreW = (PrescaleDiv > 1) ? $clog2(PrescaleDiv) : 1;

    logic [PreW-1:0]                   pre_cnt;
    logic [PwmBits-1:0]                pwm_cnt;
    logic [NumLeds-1:0][PwmBits-1:0]   active;
    logic                              pre_wrap;

    assign pre_wrap = (pre_cnt == PreW'(PrescaleDiv - 1));

    // Duties only change at the counter wrap so a period never mixes two values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
            active  <= '0;
            led     <= '0;
        end else begin
            for (int i = 0; i < NumLeds; i++) begin
                led[i] <= (active[i] > pwm_cnt);
            end
            if (pre_wrap) begin
                pre_cnt <= '0;
                pwm_cnt <= pwm_cnt + 1'b1;
                if (pwm_cnt == '1) begin
                    active <= shadow;
                end
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_pwm_led.sv
// rtl/uart_pwm_led.sv - UART command parser, brightness registers and response slot; UART_PWM_LED_READBACK_EN enables reads
module uart_pwm_led
    import uart_pwm_led_pkg::*;
#(
    parameter int NumLeds       = 8,
    parameter int PwmBits       = 8,
    parameter int PrescaleDiv   = 64,
    parameter int TimeoutCycles = 1000000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_rx_valid,
    input  logic [7:0]         i_rx_byte,
    input  logic               i_rx_error,
    output logic               o_tx_valid,
    output logic [7:0]         o_tx_byte,
    input  logic               i_tx_ready,
    output logic [NumLeds-1:0] o_led,
    output logic               o_overrun,
    output logic               o_busy
);

    localparam int SelW = (NumLeds > 1) ? $clog2(NumLeds) : 1;
    localparam int TmoW = $clog2(TimeoutCycles);

    state_t                          state;
    logic [CMD_INDEX_W-1:0]          wr_index;
    logic [TmoW-1:0]                 tmo_cnt;
    logic [NumLeds-1:0][PwmBits-1:0] shadow;

    logic       is_write;
    logic       wr_valid;
    logic       tmo_hit;
    logic       resp_req;
    logic [7:0] resp_byte;
    logic [7:0] read_resp;

    assign is_write = i_rx_byte[CMD_WRITE_BIT];
    assign wr_valid = int'(wr_index) < NumLeds;
    assign tmo_hit  = (tmo_cnt == TmoW'(TimeoutCycles - 1));

`ifdef UART_PWM_LED_READBACK_EN
    logic rd_valid;

    assign rd_valid = int'(i_rx_byte[CMD_INDEX_MSB:0]) < NumLeds;

    always_comb begin
        read_resp = RESP_NAK;
        if (rd_valid) begin
            read_resp              = '0;
            read_resp[PwmBits-1:0] = shadow[i_rx_byte[SelW-1:0]];
        end
    end
`else
    assign read_resp = RESP_NAK;
`endif

    // A receive error outranks everything; a data byte outranks the timeout.
    always_comb begin
        resp_req  = 1'b0;
        resp_byte = RESP_NAK;
        if (i_rx_error) begin
            resp_req = 1'b1;
        end else if (state == IDLE) begin
            if (i_rx_valid && !is_write) begin
                resp_req  = 1'b1;
                resp_byte = read_resp;
            end
        end else if (i_rx_valid) begin
            resp_req  = 1'b1;
            resp_byte = wr_valid ? RESP_ACK : RESP_NAK;
        end else if (tmo_hit) begin
            resp_req = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            wr_index <= '0;
            tmo_cnt  <= '0;
            shadow   <= '0;
            o_busy   <= 1'b0;
        end else if (i_rx_error) begin
            state    <= IDLE;
            wr_index <= '0;
            o_busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_rx_valid && is_write) begin
                        state    <= WAIT_DATA;
                        wr_index <= i_rx_byte[CMD_INDEX_MSB:0];
                        tmo_cnt  <= '0;
                        o_busy   <= 1'b1;
                    end
                end
                WAIT_DATA: begin
                    if (i_rx_valid) begin
                        if (wr_valid) begin
                            shadow[wr_index[SelW-1:0]] <= i_rx_byte[PwmBits-1:0];
                        end
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else if (tmo_hit) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Single-entry slot: a same-cycle accept frees room for the new response.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_tx_valid <= 1'b0;
            o_tx_byte  <= '0;
            o_overrun  <= 1'b0;
        end else if (resp_req) begin
            if (!o_tx_valid || i_tx_ready) begin
                o_tx_valid <= 1'b1;
                o_tx_byte  <= resp_byte;
            end else begin
                o_overrun <= 1'b1;
            end
        end else if (o_tx_valid && i_tx_ready) begin
            o_tx_valid <= 1'b0;
        end
    end

    uart_pwm_led_pwm #(
        .NumLeds    (NumLeds),
        .PwmBits    (PwmBits),
        .PrescaleDiv(PrescaleDiv)
    ) u_pwm (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .shadow(shadow),
        .led   (o_led)
    );

endmodule

// File: tb/tb_uart_pwm_led.sv
// tb/tb_uart_pwm_led.sv - randomized and directed bench for uart_pwm_led against a behavioural model
module tb_uart_pwm_led;

    localparam int N   = 8;
    localparam int B   = 8;
    localparam int P   = 2;
    localparam int T   = 20;
    localparam int PER = P * (1 << B);

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         rx_valid = 1'b0;
    logic         rx_error = 1'b0;
    logic         tx_ready = 1'b1;
    logic [7:0]   rx_byte  = 8'h00;
    logic         tx_valid;
    logic         overrun;
    logic         busy;
    logic [7:0]   tx_byte;
    logic [N-1:0] led;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_pwm_led #(
        .NumLeds      (N),
        .PwmBits      (B),
        .PrescaleDiv  (P),
        .TimeoutCycles(T)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_rx_valid(rx_valid),
        .i_rx_byte (rx_byte),
        .i_rx_error(rx_error),
        .o_tx_valid(tx_valid),
        .o_tx_byte (tx_byte),
        .i_tx_ready(tx_ready),
        .o_led     (led),
        .o_overrun (overrun),
        .o_busy    (busy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: edge count since reset, pending write target, response slot.
    int           n;
    int           shadow_m[N];
    int           act_m[N];
    int           pend;
    int           age;
    bit           m_valid;
    int           m_byte;
    bit           m_ovr;
    logic [N-1:0] m_led;

    function automatic int read_val(input int idx);
`ifdef UART_PWM_LED_READBACK_EN
        return (idx < N) ? shadow_m[idx] : 'h15;
`else
        return 'h15;
`endif
    endfunction

    task automatic model_reset();
        n = 0; pend = -1; age = 0;
        m_valid = 0; m_byte = 0; m_ovr = 0; m_led = '0;
        for (int i = 0; i < N; i++) begin
            shadow_m[i] = 0;
            act_m[i]    = 0;
        end
    endtask

    task automatic model_step();
        bit resp;
        int rb;
        int idx;
        int cnt_prev;
        n++;
        cnt_prev = ((n - 1) / P) % (1 << B);
        for (int i = 0; i < N; i++) m_led[i] = (act_m[i] > cnt_prev);
        if (n % PER == 0) begin
            for (int i = 0; i < N; i++) act_m[i] = shadow_m[i];
        end
        resp = 0;
        rb   = 'h15;
        idx  = int'(rx_byte[6:0]);
        if (rx_error) begin
            resp = 1;
            pend = -1;
        end else if (pend < 0) begin
            if (rx_valid) begin
                if (rx_byte[7]) begin
                    pend = idx;
                    age  = 0;
                end else begin
                    resp = 1;
                    rb   = read_val(idx);
                end
            end
        end else if (rx_valid) begin
            resp = 1;
            if (pend < N) begin
                shadow_m[pend] = int'(rx_byte) % (1 << B);
                rb = 'h06;
            end
            pend = -1;
        end else begin
            age++;
            if (age == T) begin
                resp = 1;
                pend = -1;
            end
        end
        if (resp) begin
            if (!m_valid || tx_ready) begin
                m_valid = 1;
                m_byte  = rb;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && tx_ready) begin
            m_valid = 0;
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
            chk("m_rst_tx_byte", tx_byte, 0);
        end else begin
            model_step();
        end
        chk("m_tx_valid", tx_valid, m_valid);
        if (m_valid) chk("m_tx_byte", tx_byte, m_byte);
        chk("m_overrun", overrun, m_ovr);
        chk("m_busy", busy, pend >= 0);
        chk("m_led", led, m_led);
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    int rd3;
    int rd0;
    int cnt_on;
    int others;

    initial begin
`ifdef UART_PWM_LED_READBACK_EN
        rd3 = 'h40;
        rd0 = 'h00;
`else
        rd3 = 'h15;
        rd0 = 'h15;
`endif
        repeat (3) @(negedge clk);
        chk("rst_led", led, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        send(8'h83);
        chk("busy_after_cmd", busy, 1);
        send(8'h40);
        chk("wr_ack_valid", tx_valid, 1);
        chk("wr_ack_byte", tx_byte, 8'h06);
        chk("busy_after_data", busy, 0);

        repeat (2 * PER) @(negedge clk);
        cnt_on = 0;
        others = 0;
        repeat (PER) begin
            @(negedge clk);
            cnt_on += int'(led[3]);
            if ((led & 8'hF7) != 0) others++;
        end
        chk("led3_on_clocks", cnt_on, 64 * P);
        chk("other_leds_off", others, 0);

        send(8'h03);
        chk("read_ch3", tx_byte, rd3);
        send(8'h8A);
        send(8'h55);
        chk("bad_index_nak", tx_byte, 8'h15);
        send(8'h0A);
        chk("bad_read_nak", tx_byte, 8'h15);

        send(8'h81);
        repeat (T - 1) @(negedge clk);
        chk("busy_before_tmo", busy, 1);
        chk("no_resp_before_tmo", tx_valid, 0);
        @(negedge clk);
        chk("tmo_valid", tx_valid, 1);
        chk("tmo_nak", tx_byte, 8'h15);
        chk("tmo_busy_drop", busy, 0);
        send(8'h81);
        send(8'hFF);
        chk("ack_after_tmo", tx_byte, 8'h06);

        send(8'h82);
        rx_error = 1'b1;
        rx_valid = 1'b1;
        rx_byte  = 8'h33;
        @(negedge clk);
        rx_error = 1'b0;
        rx_valid = 1'b0;
        chk("err_nak", tx_byte, 8'h15);
        chk("err_idle", busy, 0);
        send(8'h02);
        chk("err_no_write", tx_byte, rd0);

        @(negedge clk);
        tx_ready = 1'b0;
        send(8'h03);
        send(8'h0C);
        chk("ovr_flag", overrun, 1);
        chk("ovr_first_held", tx_byte, rd3);
        tx_ready = 1'b1;
        @(negedge clk);
        chk("ovr_drained", tx_valid, 0);
        repeat (2) @(negedge clk);
        chk("ovr_single_xfer", tx_valid, 0);

        send(8'h85);
        rx_valid = 1'b1;
        rx_byte  = 8'h77;
        rst_n    = 1'b0;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("rst_mid_led", led, 0);
        chk("rst_mid_tx_valid", tx_valid, 0);
        chk("rst_mid_overrun", overrun, 0);
        chk("rst_mid_busy", busy, 0);
        rst_n = 1'b1;
        send(8'h05);
        chk("rst_mid_no_write", tx_byte, rd0);
        send(8'h03);
        chk("rst_cleared_ch3", tx_byte, rd0);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst_n = (c != 2000);
            if (c % 500 >= 470) begin
                rx_valid = 1'b0;
                rx_error = 1'b0;
            end else begin
                rx_valid = ($urandom_range(0, 3) == 0);
                rx_byte  = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 3) != 0) rx_byte[6:0] = 7'($urandom_range(0, 11));
                rx_error = ($urandom_range(0, 60) == 0);
            end
            tx_ready = ($urandom_range(0, 4) != 0);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        rx_valid = 1'b0;
        rx_error = 1'b0;
        tx_ready = 1'b1;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
